image_ram_stream: RTL and testbench
===================================

// Module: image_ram_stream
// PURPOSE
//  Parametrised successor to the training-image RAM. Holds DEPTH packed samples of
//  {pixels, one-hot label}. After a start command it streams one epoch of samples on a
//  valid/ready interface, in sequential or fixed-stride (pseudo-shuffled) order.
//  Sits between dataset storage and the learner core; the learner back-pressures via out_ready.
// PARAMETERS
//  ADDR_WIDTH   16               address bits; 2**ADDR_WIDTH >= DEPTH
//  DATA_WIDTH   794              bits per stored sample = PIX_WIDTH + LABEL_WIDTH
//  LABEL_WIDTH  10               one-hot label field, in the LSBs of each word
//  DEPTH        60000            number of sample words
//  STRIDE       7919             address step in stride mode; 0 < STRIDE < DEPTH
//  INIT_FILE    "final_train.mem" $readmemb image; "" disables preload
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            synchronous, active-high
//  wr_en        in   1            load-port write strobe (honoured in IDLE only)
//  wr_addr      in   ADDR_WIDTH   load-port address
//  wr_data      in   DATA_WIDTH   load-port data
//  wr_drop      out  1            1-cycle pulse: wr_en seen while not IDLE, write discarded
//  start        in   1            begin epoch (honoured in IDLE only)
//  mode         in   1            sampled at start: 0 = sequential, 1 = stride
//  num_samples  in   ADDR_WIDTH+1 sampled at start; samples per epoch; values > DEPTH clamp to DEPTH
//  start_offset in   ADDR_WIDTH   sampled at start; first offset; must be < num_samples
//  busy         out  1            high while state != IDLE
//  out_valid    out  1            sample available
//  out_ready    in   1            consumer accepts when out_valid & out_ready
//  out_pixels   out  DATA_WIDTH-LABEL_WIDTH  word[DATA_WIDTH-1:LABEL_WIDTH]
//  out_label    out  LABEL_WIDTH  word[LABEL_WIDTH-1:0]
//  out_index    out  ADDR_WIDTH   RAM address of the presented sample
//  out_last     out  1            presented sample is the last of the epoch
//  epoch_done   out  1            1-cycle pulse after the final handshake
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_last, busy, epoch_done, wr_drop = 0; out_index = 0;
//   buffer flushed; in-flight read discarded; RAM contents preserved (never cleared).
//  FSM: IDLE -(start)-> RUN -(all reads issued)-> DRAIN -(last handshake)-> IDLE.
//   On start with num_samples==0: go straight to IDLE, pulse epoch_done next cycle, no output.
//   start while busy: ignored.
//  RAM: one port, registered read, 1-cycle latency. Address mux = wr_addr in IDLE,
//   read pointer otherwise. A read with a concurrent write is impossible by construction.
//  Read issue (RUN): issue when remaining > 0 and (buffer occupancy + in-flight) < 2.
//   The 2-entry output FIFO therefore never overflows; full throughput is 1 sample/cycle
//   with out_ready held high.
//  Latency: start high in cycle 0 -> first read in cycle 1 -> out_valid high in cycle 3.
//  Address order: ptr = start_offset; next = ptr + step, where step = 1 (mode 0) or
//   STRIDE (mode 1); if next >= N then next -= N (N = clamped num_samples). Arithmetic is
//   ADDR_WIDTH+1 bits wide, so there is no overflow. Full coverage in mode 1 requires
//   gcd(STRIDE, N) = 1; that is the caller's duty and is not checked.
//  Outputs hold stable while out_valid & !out_ready (AXI-style; no retraction).
//  out_last is set with the N-th sample. epoch_done pulses in the cycle after its
//   handshake, and busy drops in that same cycle.
//  rst mid-epoch: immediate return to IDLE per reset values; the next start begins afresh.
// STRUCTURE
//  Package image_ram_pkg: PIX_WIDTH = 784, LABEL_WIDTH = 10, state enum
//   {ST_IDLE, ST_RUN, ST_DRAIN}, MODE_SEQ / MODE_STRIDE constants.
//  Sub-module image_ram_core: single-port RAM (ram_style "ultra"), en/we/addr/din/dout,
//   INIT_FILE preload. The top level holds the FSM, address generator, counters and 2-entry FIFO.
// TESTING (bench: DEPTH=16, DATA_WIDTH=18, LABEL_WIDTH=10, STRIDE=5; word[i] = i*3)
//  1 Load all 16 words in IDLE; start mode0, N=16, offset 0, ready=1 -> out_index 0..15 on
//    consecutive cycles from cycle 3; data = i*3; out_last only on index 15; epoch_done once.
//  2 mode1, N=16, offset 2 -> index order 2,7,12,1,6,11,0,5,10,15,4,9,14,3,8,13.
//  3 Random out_ready (50%) -> same sequence as 1; no drops/dups; payload stable while stalled.
//  4 wr_en during RUN -> wr_drop pulses, RAM unchanged (verified by re-streaming);
//    start during RUN -> ignored.
//  5 N=0 -> epoch_done 1 cycle after start, out_valid never high; N=20 -> clamps to 16 samples.
//  6 rst asserted after 5 handshakes -> next cycle out_valid=0, busy=0; new start -> restarts at offset.

Source files
------------

// File: rtl/image_ram_pkg.sv
// Shared types and constants for the training-image RAM streamer.
package image_ram_pkg;

  localparam int PIX_WIDTH   = 784;
  localparam int LABEL_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam logic MODE_SEQ    = 1'b0;
  localparam logic MODE_STRIDE = 1'b1;

endpackage

// File: rtl/image_ram_core.sv
// Single-port sample RAM with a registered read (1-cycle latency).
module image_ram_core #(
  parameter int    ADDR_WIDTH = 16,
  parameter int    DATA_WIDTH = 794,
  parameter int    DEPTH      = 60000,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  import image_ram_pkg::*;

  (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dout_q;

  // Contents are never cleared; a write cycle does not update the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      else    dout_q    <= mem[addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/image_ram_stream.sv
// Streams one epoch of stored {pixels, label} samples in sequential or stride order.
module image_ram_stream #(
  parameter int    ADDR_WIDTH  = 16,
  parameter int    DATA_WIDTH  = 794,
  parameter int    LABEL_WIDTH = 10,
  parameter int    DEPTH       = 60000,
  parameter int    STRIDE      = 7919,
  parameter string INIT_FILE   = "final_train.mem"
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_en,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              wr_drop,
  input  logic                              start,
  input  logic                              mode,
  input  logic [ADDR_WIDTH:0]               num_samples,
  input  logic [ADDR_WIDTH-1:0]             start_offset,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-LABEL_WIDTH-1:0] out_pixels,
  output logic [LABEL_WIDTH-1:0]            out_label,
  output logic [ADDR_WIDTH-1:0]             out_index,
  output logic                              out_last,
  output logic                              epoch_done
);
  import image_ram_pkg::*;

  localparam int             CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]  STRIDE_C = CW'(STRIDE);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);

  state_t                state_q, state_d;
  logic [CW-1:0]         ptr_q, ptr_d, n_q, n_d, step_q, step_d, rem_q, rem_d;
  logic                  infl_q, infl_d, infl_last_q, infl_last_d;
  logic [ADDR_WIDTH-1:0] infl_idx_q, infl_idx_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d, t_data_q, t_data_d;
  logic [ADDR_WIDTH-1:0] h_idx_q, h_idx_d, t_idx_q, t_idx_d;
  logic                  h_last_q, h_last_d, t_last_q, t_last_d;
  logic                  done_q, done_d, drop_q, drop_d;

  logic                  pop, issue;
  logic [1:0]            occ;
  logic [CW-1:0]         ptr_sum, ptr_next, n_clamp;
  logic                  ram_en, ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Output handshake: a sample transfers in any cycle where out_valid && out_ready;
  // once out_valid rises the head entry is held unchanged until it transfers.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    n_d         = n_q;
    step_d      = step_q;
    rem_d       = rem_q;
    infl_d      = 1'b0;
    infl_idx_d  = infl_idx_q;
    infl_last_d = infl_last_q;
    h_data_d    = h_data_q;
    h_idx_d     = h_idx_q;
    h_last_d    = h_last_q;
    t_data_d    = t_data_q;
    t_idx_d     = t_idx_q;
    t_last_d    = t_last_q;
    done_d      = 1'b0;
    drop_d      = wr_en && (state_q != ST_IDLE);

    pop      = (cnt_q != 2'd0) && out_ready;
    occ      = cnt_q - {1'b0, pop};
    // Counting this cycle's pop lets a read issue every cycle under full throughput.
    issue    = (state_q == ST_RUN) && (rem_q != '0) && ((occ + {1'b0, infl_q}) < 2'd2);
    ptr_sum  = ptr_q + step_q;
    ptr_next = (ptr_sum >= n_q) ? (ptr_sum - n_q) : ptr_sum;
    n_clamp  = (num_samples > DEPTH_C) ? DEPTH_C : num_samples;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            n_d     = n_clamp;
            rem_d   = n_clamp;
            ptr_d   = {1'b0, start_offset};
            step_d  = (mode == MODE_STRIDE) ? STRIDE_C : ONE_C;
          end
        end
      end
      ST_RUN: begin
        if (issue && (rem_q == ONE_C)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && h_last_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      infl_d      = 1'b1;
      infl_idx_d  = ptr_q[ADDR_WIDTH-1:0];
      infl_last_d = (rem_q == ONE_C);
      rem_d       = rem_q - ONE_C;
      ptr_d       = ptr_next;
    end

    if (pop) begin
      h_data_d = t_data_q;
      h_idx_d  = t_idx_q;
      h_last_d = t_last_q;
    end
    if (infl_q) begin
      if (occ == 2'd0) begin
        h_data_d = ram_dout;
        h_idx_d  = infl_idx_q;
        h_last_d = infl_last_q;
      end else begin
        t_data_d = ram_dout;
        t_idx_d  = infl_idx_q;
        t_last_d = infl_last_q;
      end
    end
    cnt_d = occ + {1'b0, infl_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      n_q         <= '0;
      step_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_idx_q  <= '0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      h_idx_q     <= '0;
      h_last_q    <= 1'b0;
      t_idx_q     <= '0;
      t_last_q    <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      n_q         <= n_d;
      step_q      <= step_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_idx_q  <= infl_idx_d;
      infl_last_q <= infl_last_d;
      cnt_q       <= cnt_d;
      h_idx_q     <= h_idx_d;
      h_last_q    <= h_last_d;
      t_idx_q     <= t_idx_d;
      t_last_q    <= t_last_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  // Payload registers need no reset: they are qualified by cnt_q.
  always_ff @(posedge clk) begin
    h_data_q <= h_data_d;
    t_data_q <= t_data_d;
  end

  assign ram_we   = (state_q == ST_IDLE) && wr_en;
  assign ram_en   = ram_we || issue;
  assign ram_addr = (state_q == ST_IDLE) ? wr_addr : ptr_q[ADDR_WIDTH-1:0];

  image_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_FILE  (INIT_FILE)
  ) u_core (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (wr_data),
    .dout (ram_dout)
  );

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (cnt_q != 2'd0);
  assign out_last   = (cnt_q != 2'd0) && h_last_q;
  assign out_index  = h_idx_q;
  assign out_pixels = h_data_q[DATA_WIDTH-1:LABEL_WIDTH];
  assign out_label  = h_data_q[LABEL_WIDTH-1:0];
  assign epoch_done = done_q;
  assign wr_drop    = drop_q;

endmodule

// File: tb/tb_image_ram_stream.sv
// Directed bench for image_ram_stream: 16-word RAM, word[i] = i*3, stride 5.
module tb_image_ram_stream;

  localparam int AW = 4;
  localparam int DW = 18;
  localparam int LW = 10;
  localparam int DP = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_drop;
  logic          start;
  logic          mode;
  logic [AW:0]   num_samples;
  logic [AW-1:0] start_offset;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-LW-1:0] out_pixels;
  logic [LW-1:0] out_label;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          epoch_done;

  int total = 0;
  int bad   = 0;
  int done_pulses = 0;
  int exp_done    = 0;

  logic [DW-1:0] mem_model [DP];
  logic [AW-1:0] exp_q[$];

  image_ram_stream #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .LABEL_WIDTH (LW),
    .DEPTH       (DP),
    .STRIDE      (5),
    .INIT_FILE   ("")
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_drop      (wr_drop),
    .start        (start),
    .mode         (mode),
    .num_samples  (num_samples),
    .start_offset (start_offset),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pixels   (out_pixels),
    .out_label    (out_label),
    .out_index    (out_index),
    .out_last     (out_last),
    .epoch_done   (epoch_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (epoch_done) done_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic start_epoch(input logic m, input logic [AW:0] n, input logic [AW-1:0] off);
    start        = 1'b1;
    mode         = m;
    num_samples  = n;
    start_offset = off;
    tick();
    start        = 1'b0;
  endtask

  // Checks every presented sample against the head of exp_q until the queue drains.
  task automatic stream_check(input string tag, input bit rnd);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        chk({tag, " idx"}, 32'(out_index), 32'(exp_q[0]));
        chk({tag, " label"}, 32'(out_label), 32'(mem_model[exp_q[0]][LW-1:0]));
        if (out_ready) begin
          chk({tag, " pixels"}, 32'(out_pixels), 32'(mem_model[exp_q[0]][DW-1:LW]));
          chk({tag, " last"}, 32'(out_last), 32'(exp_q.size() == 1));
          void'(exp_q.pop_front());
        end
      end
      tick();
      cyc++;
    end
    chk({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    exp_done++;
    chk({tag, " epoch_done"}, 32'(epoch_done), 32'd1);
    chk({tag, " busy_low"}, 32'(busy), 32'd0);
    out_ready = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] order2 [16];
    order2 = '{4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11, 4'd0, 4'd5,
               4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3, 4'd8, 4'd13};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; mode = 1'b0; num_samples = '0; start_offset = '0; out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();

    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset out_index", 32'(out_index), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    chk("reset epoch_done", 32'(epoch_done), 32'd0);
    chk("reset wr_drop", 32'(wr_drop), 32'd0);

    // 1: load and stream sequentially with exact timing
    for (int i = 0; i < DP; i++) begin
      mem_model[i] = DW'(i * 3);
      write_word(AW'(i), DW'(i * 3));
    end
    chk("t1 no drop in idle", 32'(wr_drop), 32'd0);
    start_epoch(1'b0, 5'd16, 4'd0);
    chk("t1 c1 busy", 32'(busy), 32'd1);
    chk("t1 c1 valid", 32'(out_valid), 32'd0);
    tick();
    chk("t1 c2 valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < DP; i++) begin
      chk("t1 valid", 32'(out_valid), 32'd1);
      chk("t1 idx", 32'(out_index), 32'(i));
      chk("t1 label", 32'(out_label), 32'(i * 3));
      chk("t1 last", 32'(out_last), 32'(i == 15));
      tick();
    end
    exp_done++;
    chk("t1 epoch_done", 32'(epoch_done), 32'd1);
    chk("t1 busy", 32'(busy), 32'd0);
    chk("t1 valid after", 32'(out_valid), 32'd0);
    tick();
    chk("t1 done pulse once", 32'(epoch_done), 32'd0);
    chk("t1 done count", 32'(done_pulses), 32'(exp_done));

    // 2: stride order
    for (int i = 0; i < 16; i++) exp_q.push_back(order2[i]);
    start_epoch(1'b1, 5'd16, 4'd2);
    stream_check("t2", 1'b0);
    tick();

    // 3: random back-pressure, sequential
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
    start_epoch(1'b0, 5'd16, 4'd0);
    stream_check("t3", 1'b1);
    tick();

    // 4: write and start while busy are discarded
    out_ready = 1'b0;
    start_epoch(1'b0, 5'd16, 4'd0);
    tick();
    write_word(4'd3, 18'h3ffff);
    chk("t4 wr_drop pulse", 32'(wr_drop), 32'd1);
    start_epoch(1'b1, 5'd16, 4'd5);
    chk("t4 wr_drop clears", 32'(wr_drop), 32'd0);
    chk("t4 busy", 32'(busy), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
    stream_check("t4", 1'b0);
    tick();
    chk("t4 no restart", 32'(busy), 32'd0);

    // 5: empty epoch, then clamped epoch
    start_epoch(1'b0, 5'd0, 4'd0);
    exp_done++;
    chk("t5 n0 epoch_done", 32'(epoch_done), 32'd1);
    chk("t5 n0 busy", 32'(busy), 32'd0);
    chk("t5 n0 valid", 32'(out_valid), 32'd0);
    tick();
    chk("t5 n0 valid later", 32'(out_valid), 32'd0);
    chk("t5 n0 done pulse", 32'(epoch_done), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(i));
    start_epoch(1'b0, 5'd20, 4'd0);
    stream_check("t5 clamp", 1'b0);
    tick();
    chk("t5 clamp stops", 32'(out_valid), 32'd0);

    // 6: reset mid-epoch, then restart from the offset
    start_epoch(1'b0, 5'd16, 4'd4);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("t6 pre idx", 32'(out_index), 32'(4 + i));
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 rst valid", 32'(out_valid), 32'd0);
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst index", 32'(out_index), 32'd0);
    tick();
    chk("t6 no done after abort", 32'(epoch_done), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'((4 + i) % 16));
    start_epoch(1'b0, 5'd16, 4'd4);
    stream_check("t6", 1'b0);
    tick();
    chk("t6 done count", 32'(done_pulses), 32'(exp_done));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
